// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches one instruction at a time from instruction memory and presents it in
// the IF/ID register. A request is issued at the current pc, held until
// granted, and the response is parked in a hold register until the memory
// stage completes (IF_DONE && MEM_DONE). On that advance edge the instruction
// retires into IF/ID, is held back by stall, or is squashed by flush.
//
// Optional feature (compile-time macro IF_BYPASS_EN):
//   When defined, a response arriving in WAIT raises IF_DONE in the same
//   cycle, so the instruction can retire straight from im_rdata and DONE is
//   skipped (2 cycles per instruction instead of 3).
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   pc         in   [31:0] fetch address from the program counter
//   stall      in   hold IF/ID and the current instruction
//   flush      in   squash the current instruction (wins over stall)
//   MEM_DONE   in   memory stage complete; gates every IF/ID update
//   im_req     out  instruction-memory request
//   im_addr    out  [31:0] request address (pc while requesting, else 0)
//   im_gnt     in   request accepted
//   im_rvalid  in   response valid
//   im_rdata   in   [31:0] response data
//   IF_DONE    out  a fetched instruction is available for pc
//   if_inst    out  [31:0] IF/ID instruction
//   if_pc      out  [31:0] IF/ID pc
//   if_valid   out  IF/ID valid
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        flush,
   input  logic        MEM_DONE,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic        IF_DONE,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] hold_inst;
   logic [31:0] load_inst;
   logic        advance;
   logic        retire;

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next state and handshake outputs ----
   always_comb begin
      state_nxt = state;
      im_req    = 1'b0;
      im_addr   = '0;
      IF_DONE   = (state == DONE);
`ifdef IF_BYPASS_EN
      // A response in WAIT is usable in the same cycle it arrives.
      if (state == WAIT && im_rvalid) begin
         IF_DONE = 1'b1;
      end
`endif
      advance = IF_DONE && MEM_DONE;
      // The current instruction is consumed (retired or squashed) unless a
      // stall without flush holds it.
      retire  = advance && (flush || !stall);
      // Only reachable from WAIT in the bypass build, where the hold register
      // has not been written yet.
      load_inst = (state == WAIT) ? im_rdata : hold_inst;

      unique case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            im_req  = 1'b1;
            im_addr = pc;
            if (im_gnt) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (im_rvalid) begin
               state_nxt = retire ? REQ : DONE;
            end
         end
         DONE: begin
            if (retire) begin
               state_nxt = REQ;
            end
         end
      endcase
   end

   // ---- fetch-PC, hold register and IF/ID ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc  <= '0;
         hold_inst <= '0;
         if_inst   <= RESET_INST;
         if_pc     <= '0;
         if_valid  <= 1'b0;
      end else begin
         if (state == REQ && im_gnt) begin
            fetch_pc <= pc;
         end
         if (state == WAIT && im_rvalid) begin
            hold_inst <= im_rdata;
         end
         if (advance && flush) begin
            if_inst  <= RESET_INST;
            if_pc    <= '0;
            if_valid <= 1'b0;
         end else if (advance && !stall) begin
            if_inst  <= load_inst;
            if_pc    <= fetch_pc;
            if_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Randomised bench for instr_fetch_unit. A driver process plays the program
// counter, the pipeline control inputs and a randomly-delayed instruction
// memory; every response it returns is pushed into a scoreboard queue. A
// monitor process keeps a small transaction-level model (idle / request
// outstanding / instruction available) and, each cycle, checks the handshake
// outputs and the IF/ID register, popping the scoreboard whenever an
// instruction is retired or squashed.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_BYPASS_EN
   localparam bit BYP    = 1'b1;
   localparam int PERIOD = 2;
`else
   localparam bit BYP    = 1'b0;
   localparam int PERIOD = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        stall, flush, MEM_DONE;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_gnt, im_rvalid;
   logic [31:0] im_rdata;
   logic        IF_DONE;
   logic [31:0] if_inst, if_pc;
   logic        if_valid;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_INST(NOP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pc       (pc),
      .stall    (stall),
      .flush    (flush),
      .MEM_DONE (MEM_DONE),
      .im_req   (im_req),
      .im_addr  (im_addr),
      .im_gnt   (im_gnt),
      .im_rvalid(im_rvalid),
      .im_rdata (im_rdata),
      .IF_DONE  (IF_DONE),
      .if_inst  (if_inst),
      .if_pc    (if_pc),
      .if_valid (if_valid)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } fetch_t;

   fetch_t sbq[$];

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver knobs / memory responder state ----------------
   int       gnt_pct, dly_min, dly_max, md_pct, stall_pct, flush_pct, spur_pct;
   bit       first_data;
   bit       tp_mode;
   bit       r_out;
   int       r_dly;
   logic [31:0] r_pc;

   function automatic logic [31:0] pick_pc();
      int sel;
      sel = $urandom_range(3);
      if (sel == 0) return 32'hFFFF_FFFC;
      if (sel == 1) return 32'h0000_0000;
      return $urandom & 32'hFFFF_FFFC;
   endfunction

   task automatic drive_cycle();
      @(negedge clk);
      im_rvalid = 1'b0;
      im_rdata  = $urandom;
      if (r_out) begin
         if (r_dly == 0) begin
            im_rvalid = 1'b1;
            if (first_data) begin
               im_rdata   = 32'h0050_0093;
               first_data = 1'b0;
            end
            sbq.push_back('{r_pc, im_rdata});
            r_out = 1'b0;
         end else begin
            r_dly--;
         end
      end else if ($urandom_range(99) < spur_pct) begin
         im_rvalid = 1'b1;   // stray response with no request outstanding
      end
      if (!im_req && $urandom_range(99) < 30) pc = pick_pc();
      im_gnt = ($urandom_range(99) < gnt_pct);
      if (im_req && im_gnt) begin
         r_out = 1'b1;
         r_pc  = pc;
         r_dly = $urandom_range(dly_max, dly_min);
      end
      MEM_DONE = ($urandom_range(99) < md_pct);
      stall    = ($urandom_range(99) < stall_pct);
      flush    = ($urandom_range(99) < flush_pct);
   endtask

   task automatic set_knobs(input int g, input int dmin, input int dmax, input int md,
                            input int st, input int fl, input int sp);
      gnt_pct = g; dly_min = dmin; dly_max = dmax; md_pct = md;
      stall_pct = st; flush_pct = fl; spur_pct = sp;
   endtask

   // ---------------- monitor / reference model ----------------
   bit          m_idle, m_out, m_have;
   logic [31:0] m_inst, m_pc;
   logic        m_valid;
   bit          exp_req, exp_done, adv;
   int          cyc = 0;
   int          last_cons = -1;
   int          n_cons = 0;
   fetch_t      e;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (rst_n !== 1'b1) begin
            check("reset_state",
                  100'({im_req, im_addr, IF_DONE, if_inst, if_pc, if_valid}),
                  100'({1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0}));
            m_idle = 1'b1; m_out = 1'b0; m_have = 1'b0;
            m_inst = NOP;  m_pc = '0;    m_valid = 1'b0;
            sbq.delete();
            last_cons = -1;
         end else begin
            check("ifid", 100'({if_inst, if_pc, if_valid}), 100'({m_inst, m_pc, m_valid}));
            exp_req = !m_idle && !m_out && !m_have;
            check("im_req", 100'(im_req), 100'(exp_req));
            if (exp_req) check("im_addr", 100'(im_addr), 100'(pc));
            exp_done = m_have || (BYP && m_out && im_rvalid);
            check("IF_DONE", 100'(IF_DONE), 100'(exp_done));
            adv = exp_done && MEM_DONE;

            if (m_idle) begin
               m_idle = 1'b0;
            end else if (exp_req) begin
               if (im_gnt) m_out = 1'b1;
            end else if (m_out && im_rvalid) begin
               m_out  = 1'b0;
               m_have = 1'b1;
            end

            if (m_have && adv && (flush || !stall)) begin
               m_have = 1'b0;
               n_cons++;
               if (sbq.size() == 0) begin
                  check("sb_nonempty", 100'(0), 100'(1));
               end else begin
                  e = sbq.pop_front();
                  if (flush) begin
                     m_inst = NOP; m_pc = '0; m_valid = 1'b0;
                  end else begin
                     m_inst = e.data; m_pc = e.addr; m_valid = 1'b1;
                     if (tp_mode && last_cons >= 0)
                        check("throughput", 100'(cyc - last_cons), 100'(PERIOD));
                     last_cons = cyc;
                  end
               end
            end
            if (!tp_mode) last_cons = -1;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0; MEM_DONE = 1'b0;
      im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
      r_out = 1'b0; r_dly = 0; r_pc = '0; first_data = 1'b1; tp_mode = 1'b0;
      set_knobs(100, 0, 0, 100, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait memory, always granted, never stalled: steady fetch rate.
      tp_mode = 1'b1;
      repeat (40) drive_cycle();
      tp_mode = 1'b0;

      // Random grants, latencies, stalls, flushes and stray responses.
      set_knobs(40, 0, 3, 75, 33, 15, 12);
      repeat (1500) drive_cycle();

      // Reset in the middle of an outstanding fetch.
      set_knobs(100, 3, 3, 100, 0, 0, 0);
      for (int i = 0; i < 50 && !r_out; i++) drive_cycle();
      n_vec++;
      if (!r_out) begin
         n_fail++;
         $display("FAIL wait_for_grant: got no grant expected grant within 50 cycles");
      end
      drive_cycle();
      @(negedge clk);
      rst_n = 1'b0; r_out = 1'b0; im_rvalid = 1'b0; im_gnt = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_knobs(0, 0, 0, 100, 0, 0, 0);
      drive_cycle();
      spur_pct = 100;
      drive_cycle();
      spur_pct = 0;
      drive_cycle();

      set_knobs(40, 0, 3, 75, 33, 15, 12);
      repeat (800) drive_cycle();
      set_knobs(0, 0, 0, 0, 0, 0, 0);
      repeat (3) drive_cycle();

      n_vec++;
      if (n_cons < 100) begin
         n_fail++;
         $display("FAIL retire_count: got %0d expected at least 100", n_cons);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_INST, default 32'h0000_0013 (NOP), the instruction presented in IF/ID after reset or flush.
REQ-002 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port pc, input, 32, current fetch address from the program counter.
REQ-005 SHALL have ports stall, flush, MEM_DONE, input, 1 each, pipeline hold, redirect and memory-stage-complete.
REQ-006 SHALL have ports im_req (output, 1), im_addr (output, 32) and im_gnt (input, 1), the instruction-memory request handshake.
REQ-007 SHALL have ports im_rvalid (input, 1) and im_rdata (input, 32), the instruction-memory response.
REQ-008 SHALL have port IF_DONE, output, 1, high while a fetched instruction is held for pc.
REQ-009 SHALL have ports if_inst (32), if_pc (32) and if_valid (1), all outputs, forming the IF/ID register.

Function
REQ-010 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-011 IDLE SHALL go to REQ on the first clock after reset release.
REQ-012 In REQ: im_req=1 and im_addr=pc, both held stable until im_gnt=1; the im_req&&im_gnt edge SHALL go to WAIT and latch pc into an internal fetch-PC register.
REQ-013 In WAIT: im_rvalid=1 SHALL capture im_rdata into a hold register and go to DONE; im_rvalid outside WAIT SHALL be ignored.
REQ-014 In DONE: IF_DONE=1; the state SHALL hold until the advance edge, defined as IF_DONE&&MEM_DONE.
REQ-015 Advance with flush=1 (priority over stall): if_inst<=RESET_INST, if_valid<=0, if_pc<=0, next state REQ.
REQ-016 Advance with stall=1, flush=0: IF/ID unchanged, state stays DONE, hold register kept, no new request.
REQ-017 Advance with stall=0, flush=0: if_inst<=hold register, if_pc<=fetch-PC, if_valid<=1, next state REQ, fetching the updated pc.
REQ-018 With MEM_DONE=0, IF/ID SHALL not change in any state.
REQ-019 Only one request SHALL be outstanding; im_req=0 in WAIT and DONE.
REQ-020 Back-to-back non-stalled fetches with zero-wait memory SHALL take 3 cycles per instruction (REQ, WAIT, DONE).
REQ-021 The fetch-PC register SHALL be a full 32-bit value with no truncation; pc wrap from 32'hFFFF_FFFC to 0 SHALL need no special handling.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, im_req=0, im_addr=0, IF_DONE=0, if_inst=RESET_INST, if_pc=0, if_valid=0 and hold register=0.
REQ-023 Reset asserted mid-WAIT SHALL abandon the transaction, and a late im_rvalid after release SHALL be ignored.

Configuration
REQ-024 With IF_BYPASS_EN defined: in WAIT, im_rvalid=1 SHALL drive IF_DONE=1 combinationally in the same cycle; if MEM_DONE=1 that edge is an advance using im_rdata directly, and DONE is skipped (2 cycles per instruction).
REQ-025 Without IF_BYPASS_EN: IF_DONE SHALL be a pure function of state (DONE only), with 3-cycle minimum latency.

Verification
REQ-026 Reset release, pc=0, im_gnt=1, im_rvalid one cycle later with data 32'h0050_0093, MEM_DONE=1 -> im_addr=0 in REQ; IF_DONE high one cycle; if_inst=32'h0050_0093, if_pc=0, if_valid=1.
REQ-027 im_gnt held low 4 cycles at pc=0x10 -> im_req=1 and im_addr=0x10 stable all 4 cycles, WAIT entered only after the grant.
REQ-028 DONE with stall=1, MEM_DONE=1 for 3 cycles -> IF/ID unchanged, im_req=0 throughout, IF_DONE=1 throughout; stall drop -> if_inst loaded next edge.
REQ-029 DONE with flush=1 and stall=1 together -> if_inst=32'h0000_0013, if_valid=0, next request uses the new pc (fTarget value, e.g. 0x200).
REQ-030 rst_n low during WAIT, im_rvalid pulsed 2 cycles after release -> outputs at reset values, pulse ignored, first request at the current pc.
REQ-031 IF_BYPASS_EN build, zero-wait memory, MEM_DONE=1 -> IF_DONE coincident with im_rvalid, new instruction every 2 cycles.
